// File: rtl/input_port_controller_pkg.sv
// Shared definitions for the router input port: flit type codes, FSM states
// and small helpers for classifying flits by their type field.
package input_port_controller_pkg;

  localparam int unsigned DATA_WIDTH    = 8;
  localparam int unsigned PHIT_PER_FLIT = 2;
  localparam int unsigned FLIT_W        = PHIT_PER_FLIT * DATA_WIDTH;
  localparam int unsigned REQUEST_WIDTH = 2;
  localparam int unsigned FIFO_DEPTH    = 4;
  localparam int unsigned TYPE_W        = 2;

  typedef enum logic [TYPE_W-1:0] {
    FLIT_TYPE_HEAD_TAIL = 2'b00,
    FLIT_TYPE_HEAD      = 2'b01,
    FLIT_TYPE_BODY      = 2'b10,
    FLIT_TYPE_TAIL      = 2'b11
  } flitType_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DECODE  = 2'd1,
    ST_REQUEST = 2'd2,
    ST_FORWARD = 2'd3
  } portState_e;

  // A flit opens a packet when it carries a head marker.
  function automatic logic isHead(input flitType_e t);
    return (t == FLIT_TYPE_HEAD_TAIL) || (t == FLIT_TYPE_HEAD);
  endfunction

  // A flit closes a packet when it carries a tail marker.
  function automatic logic isTail(input flitType_e t);
    return (t == FLIT_TYPE_HEAD_TAIL) || (t == FLIT_TYPE_TAIL);
  endfunction

endpackage

// File: rtl/input_port_controller_flit_fifo.sv
// Synchronous flit buffer with registered occupancy count; front is the
// oldest stored flit. Pushes while full and pops while empty are ignored.
module input_port_controller_flit_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] pushData,
  output logic [WIDTH-1:0] front,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [CNT_W-1:0] count;
  logic             doPush;
  logic             doPop;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign front  = mem[rdPtr];

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/input_port_controller.sv
// Router ingress stage: buffers flits, has the head flit decoded, holds the
// switch-allocation request, then streams the packet to the crossbar.
module input_port_controller
  import input_port_controller_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [FLIT_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     decodeHeadFlit,
  output logic [FLIT_W-1:0]        HeadFlit,
  input  logic                     headFlitDecoded,
  input  logic [REQUEST_WIDTH-1:0] RequestMessage,
  output logic                     sa_req,
  output logic [REQUEST_WIDTH-1:0] sa_port,
  input  logic                     sa_grant,
  output logic                     out_valid,
  output logic [FLIT_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic                     err_no_head
);

  portState_e        state;
  logic [FLIT_W-1:0] front;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              fifoPush;
  logic              fifoPop;
  logic              discard;
  logic              sendPop;
  flitType_e         frontType;

  assign frontType = flitType_e'(front[FLIT_W-1 -: TYPE_W]);

  assign in_ready  = !fifoFull;
  assign fifoPush  = in_valid && !fifoFull;
  assign HeadFlit  = front;
  assign out_data  = front;
  assign out_valid = (state == ST_FORWARD) && !fifoEmpty;

  // A flit without a head marker at the front of an idle port is orphaned.
  assign discard = (state == ST_IDLE) && !fifoEmpty && !isHead(frontType);
  assign sendPop = out_valid && out_ready;
  assign fifoPop = discard || sendPop;

  input_port_controller_flit_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifoPush),
    .pop      (fifoPop),
    .pushData (in_data),
    .front    (front),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  // Packet FSM; decodeHeadFlit and sa_req are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      decodeHeadFlit <= 1'b0;
      sa_req         <= 1'b0;
      sa_port        <= '0;
      err_no_head    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifoEmpty) begin
            if (isHead(frontType)) begin
              state          <= ST_DECODE;
              decodeHeadFlit <= 1'b1;
            end else begin
              err_no_head <= 1'b1;
            end
          end
        end
        ST_DECODE: begin
          if (headFlitDecoded) begin
            sa_port        <= RequestMessage;
            state          <= ST_REQUEST;
            decodeHeadFlit <= 1'b0;
            sa_req         <= 1'b1;
          end
        end
        ST_REQUEST: begin
          if (sa_grant) begin
            state  <= ST_FORWARD;
            sa_req <= 1'b0;
          end
        end
        ST_FORWARD: begin
          if (sendPop && isTail(frontType)) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state          <= ST_IDLE;
          decodeHeadFlit <= 1'b0;
          sa_req         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_port_controller.sv
// Directed vector bench for input_port_controller: one record per clock cycle
// holding the inputs to drive and the outputs expected during that cycle.
module tb_input_port_controller;
  import input_port_controller_pkg::*;

  logic                     clk;
  logic                     rst;
  logic                     in_valid;
  logic [FLIT_W-1:0]        in_data;
  logic                     in_ready;
  logic                     decodeHeadFlit;
  logic [FLIT_W-1:0]        HeadFlit;
  logic                     headFlitDecoded;
  logic [REQUEST_WIDTH-1:0] RequestMessage;
  logic                     sa_req;
  logic [REQUEST_WIDTH-1:0] sa_port;
  logic                     sa_grant;
  logic                     out_valid;
  logic [FLIT_W-1:0]        out_data;
  logic                     out_ready;
  logic                     err_no_head;

  input_port_controller dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .decodeHeadFlit  (decodeHeadFlit),
    .HeadFlit        (HeadFlit),
    .headFlitDecoded (headFlitDecoded),
    .RequestMessage  (RequestMessage),
    .sa_req          (sa_req),
    .sa_port         (sa_port),
    .sa_grant        (sa_grant),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_ready       (out_ready),
    .err_no_head     (err_no_head)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        iv;
    logic [15:0] id;
    logic        hd;
    logic [1:0]  rm;
    logic        gr;
    logic        ordy;
    logic        eInRdy;
    logic        eDec;
    logic        eReq;
    logic [1:0]  ePort;
    logic        eOv;
    logic        eErr;
    logic [15:0] eFlit;   // HeadFlit when eDec, out_data when eOv
  } vec_t;

  vec_t vecs[$];
  int   applied;
  int   miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input string name,
                              input logic r, input logic iv, input logic [15:0] id,
                              input logic hd, input logic [1:0] rm, input logic gr,
                              input logic ordy, input logic eInRdy, input logic eDec,
                              input logic eReq, input logic [1:0] ePort, input logic eOv,
                              input logic eErr, input logic [15:0] eFlit);
    vec_t v;
    v.name = name; v.rst = r; v.iv = iv; v.id = id; v.hd = hd; v.rm = rm;
    v.gr = gr; v.ordy = ordy; v.eInRdy = eInRdy; v.eDec = eDec; v.eReq = eReq;
    v.ePort = ePort; v.eOv = eOv; v.eErr = eErr; v.eFlit = eFlit;
    vecs.push_back(v);
  endfunction

  task automatic checkVec(input vec_t v);
    logic [6:0]  gotS;
    logic [6:0]  expS;
    logic [15:0] gotF;
    logic        bad;
    gotS = {in_ready, decodeHeadFlit, sa_req, sa_port, out_valid, err_no_head};
    expS = {v.eInRdy, v.eDec, v.eReq, v.ePort, v.eOv, v.eErr};
    gotF = v.eDec ? HeadFlit : out_data;
    bad  = (gotS !== expS) || ((v.eDec || v.eOv) && (gotF !== v.eFlit));
    applied++;
    if (bad) begin
      miscompares++;
      $display("FAIL %s: got {rdy,dec,req,port,ov,err}=%b flit=%h, expected %b flit=%h",
               v.name, gotS, gotF, expS, v.eFlit);
    end
  endtask

  initial begin
    applied     = 0;
    miscompares = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; headFlitDecoded = 1'b0;
    RequestMessage = '0; sa_grant = 1'b0; out_ready = 1'b0;

    //   name            rst iv data     hd rm gr or | rdy dec req port ov err flit
    // Single head+tail flit, same-cycle decode, immediate grant
    add("t1_reset",       0, 1, 16'h00A1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 16'h0);
    add("t1_idle",        0, 0, 16'h0,    0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 16'h0);
    add("t1_decode",      0, 0, 16'h0,    1, 2, 0, 0,  1, 1, 0, 0, 0, 0, 16'h00A1);
    add("t1_request",     0, 0, 16'h0,    0, 0, 1, 0,  1, 0, 1, 2, 0, 0, 16'h0);
    add("t1_forward",     0, 0, 16'h0,    0, 0, 0, 1,  1, 0, 0, 2, 1, 0, 16'h00A1);
    add("t1_idle_after",  0, 0, 16'h0,    0, 0, 0, 0,  1, 0, 0, 2, 0, 0, 16'h0);
    // Four-flit packet with out_ready 1,0,1,1,0,1
    add("t2_push_head",   0, 1, 16'h4101, 0, 0, 0, 0,  1, 0, 0, 2, 0, 0, 16'h0);
    add("t2_push_b1",     0, 1, 16'h8102, 0, 0, 0, 0,  1, 0, 0, 2, 0, 0, 16'h0);
    add("t2_decode",      0, 1, 16'h8103, 1, 1, 0, 0,  1, 1, 0, 2, 0, 0, 16'h4101);
    add("t2_request",     0, 1, 16'hC104, 0, 0, 1, 0,  1, 0, 1, 1, 0, 0, 16'h0);
    add("t2_out_head",    0, 0, 16'h0,    0, 0, 0, 1,  0, 0, 0, 1, 1, 0, 16'h4101);
    add("t2_stall1",      0, 0, 16'h0,    0, 0, 0, 0,  1, 0, 0, 1, 1, 0, 16'h8102);
    add("t2_out_b1",      0, 0, 16'h0,    0, 0, 0, 1,  1, 0, 0, 1, 1, 0, 16'h8102);
    add("t2_out_b2",      0, 0, 16'h0,    0, 0, 0, 1,  1, 0, 0, 1, 1, 0, 16'h8103);
    add("t2_stall2",      0, 0, 16'h0,    0, 0, 0, 0,  1, 0, 0, 1, 1, 0, 16'hC104);
    add("t2_out_tail",    0, 0, 16'h0,    0, 0, 0, 1,  1, 0, 0, 1, 1, 0, 16'hC104);
    add("t2_idle",        0, 0, 16'h0,    0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 16'h0);
    // Orphan body flit discarded, following head decoded normally
    add("t4_push_body",   0, 1, 16'h8201, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 16'h0);
    add("t4_push_head",   0, 1, 16'h0202, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 16'h0);
    add("t4_err_set",     0, 0, 16'h0,    0, 0, 0, 0,  1, 0, 0, 1, 0, 1, 16'h0);
    add("t4_decode",      0, 0, 16'h0,    1, 3, 0, 0,  1, 1, 0, 1, 0, 1, 16'h0202);
    add("t4_request",     0, 0, 16'h0,    0, 0, 1, 0,  1, 0, 1, 3, 0, 1, 16'h0);
    add("t4_forward",     0, 0, 16'h0,    0, 0, 0, 1,  1, 0, 0, 3, 1, 1, 16'h0202);
    // Decoder answers in the third decode cycle
    add("t6_push",        0, 1, 16'h0303, 0, 0, 0, 0,  1, 0, 0, 3, 0, 1, 16'h0);
    add("t6_idle",        0, 0, 16'h0,    0, 0, 0, 0,  1, 0, 0, 3, 0, 1, 16'h0);
    add("t6_dec1",        0, 0, 16'h0,    0, 0, 0, 0,  1, 1, 0, 3, 0, 1, 16'h0303);
    add("t6_dec2",        0, 0, 16'h0,    0, 1, 0, 0,  1, 1, 0, 3, 0, 1, 16'h0303);
    add("t6_dec3",        0, 0, 16'h0,    1, 2, 0, 0,  1, 1, 0, 3, 0, 1, 16'h0303);
    add("t6_req_hold",    0, 0, 16'h0,    0, 1, 0, 0,  1, 0, 1, 2, 0, 1, 16'h0);
    add("t6_grant",       0, 0, 16'h0,    0, 0, 1, 0,  1, 0, 1, 2, 0, 1, 16'h0);
    add("t6_forward",     0, 0, 16'h0,    0, 0, 0, 1,  1, 0, 0, 2, 1, 1, 16'h0303);
    // Six back-to-back pushes into a depth-4 buffer, no grant
    add("t3_push1",       0, 1, 16'h4401, 0, 0, 0, 0,  1, 0, 0, 2, 0, 1, 16'h0);
    add("t3_push2",       0, 1, 16'h8402, 0, 0, 0, 0,  1, 0, 0, 2, 0, 1, 16'h0);
    add("t3_push3",       0, 1, 16'h8403, 1, 0, 0, 0,  1, 1, 0, 2, 0, 1, 16'h4401);
    add("t3_push4",       0, 1, 16'hC404, 0, 0, 0, 0,  1, 0, 1, 0, 0, 1, 16'h0);
    add("t3_push5_full",  0, 1, 16'h0405, 0, 0, 0, 0,  0, 0, 1, 0, 0, 1, 16'h0);
    add("t3_push6_full",  0, 1, 16'h0406, 0, 0, 0, 0,  0, 0, 1, 0, 0, 1, 16'h0);
    add("t3_grant",       0, 0, 16'h0,    0, 0, 1, 0,  0, 0, 1, 0, 0, 1, 16'h0);
    // Reset after two of four flits have left
    add("t5_out1",        0, 0, 16'h0,    0, 0, 0, 1,  0, 0, 0, 0, 1, 1, 16'h4401);
    add("t5_out2",        0, 0, 16'h0,    0, 0, 0, 1,  1, 0, 0, 0, 1, 1, 16'h8402);
    add("t5_rst",         1, 0, 16'h0,    0, 0, 0, 0,  1, 0, 0, 0, 1, 1, 16'h8403);
    add("t5_after_rst",   0, 0, 16'h0,    0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 16'h0);
    add("t5_push_head",   0, 1, 16'h0507, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 16'h0);
    add("t5_idle",        0, 0, 16'h0,    0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 16'h0);
    add("t5_decode",      0, 0, 16'h0,    0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 16'h0507);

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      checkVec(vecs[i]);
      rst             = vecs[i].rst;
      in_valid        = vecs[i].iv;
      in_data         = vecs[i].id;
      headFlitDecoded = vecs[i].hd;
      RequestMessage  = vecs[i].rm;
      sa_grant        = vecs[i].gr;
      out_ready       = vecs[i].ordy;
    end

    // Reset while waiting in DECODE returns to an idle, empty port
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; headFlitDecoded = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    applied++;
    if (decodeHeadFlit !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || sa_req !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_in_decode: got dec=%b rdy=%b ov=%b req=%b, expected dec=0 rdy=1 ov=0 req=0",
               decodeHeadFlit, in_ready, out_valid, sa_req);
    end
    @(negedge clk);
    applied++;
    if (decodeHeadFlit !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_flushed_fifo: got dec=%b, expected dec=0", decodeHeadFlit);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
